exe_mem_reg: RTL and testbench

- EXE/MEM pipeline register for the 5-stage CPU. Directly downstream of the execute stage.
- Captures the ALU result, store data, destination register and control bits for the memory stage.
- Converts a qualified ALU overflow into a precise exception request to CP0, squashing the faulting instruction and every younger instruction until CP0 acknowledges.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/exe_mem_reg_if.sv | 55 +++++
 rtl/exe_exc_fsm.sv | 97 +++++++++
 rtl/exe_mem_reg.sv | 114 +++++++++++
 tb/tb_exe_mem_reg.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, EXE/MEM exception FSM states and reset values.
package cpu_pkg;

    localparam logic [4:0] EXC_OVF = 5'd12;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_EXC_PEND = 1'b1
    } exc_state_e;

    localparam logic       RST_CTRL  = 1'b0;
    localparam logic [4:0] RST_CAUSE = 5'd0;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/exe_mem_reg_if.sv
// EXE-to-MEM bus: execute-stage inputs, hazard/CP0 controls and registered MEM-stage outputs.
// Carries ovf_cnt only when OVF_STAT_EN is defined.
interface exe_mem_reg_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    logic          stall;
    logic          flush;
    logic          e_valid;
    logic [DW-1:0] ealu;
    logic [DW-1:0] eb;
    logic [DW-1:0] epc;
    logic [RW-1:0] ern;
    logic          ewreg;
    logic          em2reg;
    logic          ewmem;
    logic          alu_overflow;
    logic          exc_ack;

    logic          mvalid;
    logic [DW-1:0] malu;
    logic [DW-1:0] mb;
    logic [DW-1:0] mpc;
    logic [RW-1:0] mrn;
    logic          mwreg;
    logic          mm2reg;
    logic          mwmem;
    logic          exc_req;
    logic [DW-1:0] exc_epc;
    logic [4:0]    exc_cause;
`ifdef OVF_STAT_EN
    logic [15:0]   ovf_cnt;
`endif

    modport master (
`ifdef OVF_STAT_EN
        input  ovf_cnt,
`endif
        output stall, flush, e_valid, ealu, eb, epc, ern, ewreg, em2reg, ewmem,
        output alu_overflow, exc_ack,
        input  mvalid, malu, mb, mpc, mrn, mwreg, mm2reg, mwmem,
        input  exc_req, exc_epc, exc_cause
    );

    modport slave (
`ifdef OVF_STAT_EN
        output ovf_cnt,
`endif
        input  stall, flush, e_valid, ealu, eb, epc, ern, ewreg, em2reg, ewmem,
        input  alu_overflow, exc_ack,
        output mvalid, malu, mb, mpc, mrn, mwreg, mm2reg, mwmem,
        output exc_req, exc_epc, exc_cause
    );

endinterface

// File: rtl/exe_exc_fsm.sv
// Overflow exception tracker: holds the first fault's EPC/cause and requests CP0 until acked.
// With OVF_STAT_EN defined, also counts accepted overflows (saturating).
module exe_exc_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned OVF_CAUSE = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          flush_i,
    input  logic          e_valid_i,
    input  logic          alu_overflow_i,
    input  logic          exc_ack_i,
    input  logic [DW-1:0] epc_i,
    output logic          pend_o,
    output logic          squash_o,
    output logic          exc_req_o,
    output logic [DW-1:0] exc_epc_o,
`ifdef OVF_STAT_EN
    output logic [15:0]   ovf_cnt_o,
`endif
    output logic [4:0]    exc_cause_o
);

    localparam logic [4:0] CauseCode = 5'(OVF_CAUSE);

    exc_state_e    state_q, state_d;
    logic [DW-1:0] exc_epc_q, exc_epc_d;
    logic [4:0]    exc_cause_q, exc_cause_d;
    logic          ovf_take;

    // Only an instruction that actually enters MEM from RUN can raise the fault.
    assign squash_o = (state_q == ST_RUN) & e_valid_i & alu_overflow_i;
    assign ovf_take = load_i & ~flush_i & squash_o;

    always_comb begin
        state_d     = state_q;
        exc_epc_d   = exc_epc_q;
        exc_cause_d = exc_cause_q;
        unique case (state_q)
            ST_RUN: begin
                if (ovf_take) begin
                    state_d     = ST_EXC_PEND;
                    exc_epc_d   = epc_i;
                    exc_cause_d = CauseCode;
                end
            end
            ST_EXC_PEND: begin
                if (exc_ack_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            exc_epc_q   <= '0;
            exc_cause_q <= RST_CAUSE;
        end else begin
            state_q     <= state_d;
            exc_epc_q   <= exc_epc_d;
            exc_cause_q <= exc_cause_d;
        end
    end

`ifdef OVF_STAT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_take && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`endif

    assign pend_o      = (state_q == ST_EXC_PEND);
    assign exc_req_o   = (state_q == ST_EXC_PEND);
    assign exc_epc_o   = exc_epc_q;
    assign exc_cause_o = exc_cause_q;

endmodule

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with precise overflow exception handoff to CP0.
// Optional feature: define OVF_STAT_EN to expose a saturating overflow counter (ovf_cnt).
module exe_mem_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned RW        = 5,
    parameter int unsigned OVF_CAUSE = 12
) (
    input logic         clk,
    input logic         rst_n,
    exe_mem_reg_if.slave bus
);

    logic          load, pend, squash;
    logic          mvalid_q, mvalid_d;
    logic          mwreg_q, mwreg_d;
    logic          mm2reg_q, mm2reg_d;
    logic          mwmem_q, mwmem_d;
    logic [DW-1:0] malu_q, malu_d;
    logic [DW-1:0] mb_q, mb_d;
    logic [DW-1:0] mpc_q, mpc_d;
    logic [RW-1:0] mrn_q, mrn_d;

    // flush overrides stall so CP0 can always inject a bubble.
    assign load = bus.flush | ~bus.stall;

    exe_exc_fsm #(
        .DW        (DW),
        .OVF_CAUSE (OVF_CAUSE)
    ) u_exc_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (load),
        .flush_i        (bus.flush),
        .e_valid_i      (bus.e_valid),
        .alu_overflow_i (bus.alu_overflow),
        .exc_ack_i      (bus.exc_ack),
        .epc_i          (bus.epc),
        .pend_o         (pend),
        .squash_o       (squash),
        .exc_req_o      (bus.exc_req),
        .exc_epc_o      (bus.exc_epc),
`ifdef OVF_STAT_EN
        .ovf_cnt_o      (bus.ovf_cnt),
`endif
        .exc_cause_o    (bus.exc_cause)
    );

    always_comb begin
        mvalid_d = mvalid_q;
        mwreg_d  = mwreg_q;
        mm2reg_d = mm2reg_q;
        mwmem_d  = mwmem_q;
        malu_d   = malu_q;
        mb_d     = mb_q;
        mpc_d    = mpc_q;
        mrn_d    = mrn_q;
        if (load) begin
            if (bus.flush || pend) begin
                // Flushed or younger than a pending fault: full bubble.
                mvalid_d = RST_CTRL;
                mwreg_d  = RST_CTRL;
                mm2reg_d = RST_CTRL;
                mwmem_d  = RST_CTRL;
                malu_d   = '0;
                mb_d     = '0;
                mpc_d    = '0;
                mrn_d    = '0;
            end else begin
                mvalid_d = bus.e_valid & ~squash;
                mwreg_d  = bus.e_valid & bus.ewreg & ~squash;
                mwmem_d  = bus.e_valid & bus.ewmem & ~squash;
                mm2reg_d = bus.e_valid & bus.em2reg;
                malu_d   = bus.ealu;
                mb_d     = bus.eb;
                mpc_d    = bus.epc;
                mrn_d    = bus.ern;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mvalid_q <= RST_CTRL;
            mwreg_q  <= RST_CTRL;
            mm2reg_q <= RST_CTRL;
            mwmem_q  <= RST_CTRL;
            malu_q   <= '0;
            mb_q     <= '0;
            mpc_q    <= '0;
            mrn_q    <= '0;
        end else begin
            mvalid_q <= mvalid_d;
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            malu_q   <= malu_d;
            mb_q     <= mb_d;
            mpc_q    <= mpc_d;
            mrn_q    <= mrn_d;
        end
    end

    assign bus.mvalid = mvalid_q;
    assign bus.mwreg  = mwreg_q;
    assign bus.mm2reg = mm2reg_q;
    assign bus.mwmem  = mwmem_q;
    assign bus.malu   = malu_q;
    assign bus.mb     = mb_q;
    assign bus.mpc    = mpc_q;
    assign bus.mrn    = mrn_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed self-checking bench for exe_mem_reg; covers ovf_cnt when OVF_STAT_EN is defined.
`timescale 1ns/1ps
module tb_exe_mem_reg;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    exe_mem_reg_if #(.DW(32), .RW(5)) bus ();

    exe_mem_reg #(.DW(32), .RW(5), .OVF_CAUSE(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0; bus.e_valid = 0; bus.ealu = '0; bus.eb = '0;
        bus.epc = '0; bus.ern = '0; bus.ewreg = 0; bus.em2reg = 0; bus.ewmem = 0;
        bus.alu_overflow = 0; bus.exc_ack = 0;
    endtask

    task automatic instr(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] rn,
                         input logic ovf);
        bus.e_valid = 1; bus.ealu = alu; bus.eb = alu ^ 32'h5A5A_0000; bus.epc = pc;
        bus.ern = rn; bus.ewreg = 1; bus.em2reg = 0; bus.ewmem = 0; bus.alu_overflow = ovf;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.mvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b want 0", bus.mvalid); end
        n_cmp++; if (bus.malu !== 32'h0) begin n_fail++; $display("FAIL reset_malu: got %h want 0", bus.malu); end
        n_cmp++; if (bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL reset_exc_req: got %b want 0", bus.exc_req); end
        n_cmp++; if (bus.exc_cause !== 5'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", bus.exc_cause); end
    endtask

    task automatic test_normal();
        instr(32'h0000_0010, 32'h0040_0000, 5'd8, 0);
        tick();
        n_cmp++; if (bus.malu !== 32'h10) begin n_fail++; $display("FAIL normal_malu: got %h want 10", bus.malu); end
        n_cmp++; if (bus.mrn !== 5'd8) begin n_fail++; $display("FAIL normal_mrn: got %0d want 8", bus.mrn); end
        n_cmp++; if (bus.mwreg !== 1'b1) begin n_fail++; $display("FAIL normal_mwreg: got %b want 1", bus.mwreg); end
        n_cmp++; if (bus.mvalid !== 1'b1) begin n_fail++; $display("FAIL normal_mvalid: got %b want 1", bus.mvalid); end
        n_cmp++; if (bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL normal_exc_req: got %b want 0", bus.exc_req); end
        n_cmp++; if (bus.mb !== 32'h5A5A_0010) begin n_fail++; $display("FAIL normal_mb: got %h want 5a5a0010", bus.mb); end
        n_cmp++; if (bus.mpc !== 32'h0040_0000) begin n_fail++; $display("FAIL normal_mpc: got %h want 00400000", bus.mpc); end
    endtask

    task automatic test_overflow();
        instr(32'h8000_0000, 32'h0040_0020, 5'd9, 1);
        tick();
        n_cmp++; if (bus.mvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_mvalid: got %b want 0", bus.mvalid); end
        n_cmp++; if (bus.mwreg !== 1'b0) begin n_fail++; $display("FAIL ovf_mwreg: got %b want 0", bus.mwreg); end
        n_cmp++; if (bus.malu !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_malu: got %h want 80000000", bus.malu); end
        n_cmp++; if (bus.mrn !== 5'd9) begin n_fail++; $display("FAIL ovf_mrn: got %0d want 9", bus.mrn); end
        n_cmp++; if (bus.exc_req !== 1'b1) begin n_fail++; $display("FAIL ovf_exc_req: got %b want 1", bus.exc_req); end
        n_cmp++; if (bus.exc_epc !== 32'h0040_0020) begin n_fail++; $display("FAIL ovf_epc: got %h want 00400020", bus.exc_epc); end
        n_cmp++; if (bus.exc_cause !== 5'd12) begin n_fail++; $display("FAIL ovf_cause: got %0d want 12", bus.exc_cause); end
        for (int i = 0; i < 3; i++) begin
            instr(32'h0000_0100 + i, 32'h0040_0024 + 4 * i, 5'd10, 0);
            tick();
            n_cmp++; if (bus.mvalid !== 1'b0 || bus.malu !== 32'h0) begin n_fail++; $display("FAIL pend_bubble%0d: got v=%b alu=%h want v=0 alu=0", i, bus.mvalid, bus.malu); end
            n_cmp++; if (bus.exc_req !== 1'b1) begin n_fail++; $display("FAIL pend_req%0d: got %b want 1", i, bus.exc_req); end
        end
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
        n_cmp++; if (bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL ack_req: got %b want 0", bus.exc_req); end
        n_cmp++; if (bus.exc_epc !== 32'h0040_0020) begin n_fail++; $display("FAIL ack_epc_hold: got %h want 00400020", bus.exc_epc); end
        instr(32'h0000_0020, 32'h0000_0180, 5'd4, 0);
        tick();
        n_cmp++; if (bus.mvalid !== 1'b1 || bus.malu !== 32'h20) begin n_fail++; $display("FAIL resume: got v=%b alu=%h want v=1 alu=20", bus.mvalid, bus.malu); end
    endtask

    task automatic test_stall_flush();
        instr(32'h0000_0030, 32'h0000_0200, 5'd3, 0);
        tick();
        bus.stall = 1;
        instr(32'hDEAD_BEEF, 32'h0000_0300, 5'd31, 0);
        bus.ewmem = 1;
        tick();
        tick();
        n_cmp++; if (bus.malu !== 32'h30 || bus.mrn !== 5'd3) begin n_fail++; $display("FAIL stall_hold: got alu=%h rn=%0d want alu=30 rn=3", bus.malu, bus.mrn); end
        n_cmp++; if (bus.mvalid !== 1'b1 || bus.mwmem !== 1'b0) begin n_fail++; $display("FAIL stall_ctrl: got v=%b wm=%b want v=1 wm=0", bus.mvalid, bus.mwmem); end
        bus.flush = 1;
        tick();
        bus.flush = 0;
        n_cmp++; if (bus.mvalid !== 1'b0 || bus.mwreg !== 1'b0 || bus.malu !== 32'h0) begin n_fail++; $display("FAIL stall_flush: got v=%b wr=%b alu=%h want 0 0 0", bus.mvalid, bus.mwreg, bus.malu); end
        instr(32'h7FFF_FFFF, 32'h0000_0304, 5'd5, 1);
        tick();
        tick();
        n_cmp++; if (bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL stall_ovf: got %b want 0", bus.exc_req); end
        n_cmp++; if (bus.malu !== 32'h0) begin n_fail++; $display("FAIL stall_ovf_hold: got %h want 0", bus.malu); end
        bus.stall = 0;
        bus.alu_overflow = 0;
        tick();
        n_cmp++; if (bus.mvalid !== 1'b1 || bus.malu !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL unstall: got v=%b alu=%h want v=1 alu=7fffffff", bus.mvalid, bus.malu); end
    endtask

    task automatic test_double_fault();
        do_reset();
        instr(32'h8000_0001, 32'h0000_0100, 5'd6, 1);
        tick();
        instr(32'h8000_0002, 32'h0000_0104, 5'd7, 1);
        tick();
        n_cmp++; if (bus.exc_epc !== 32'h0000_0100) begin n_fail++; $display("FAIL dbl_epc: got %h want 00000100", bus.exc_epc); end
        n_cmp++; if (bus.exc_req !== 1'b1 || bus.mvalid !== 1'b0) begin n_fail++; $display("FAIL dbl_state: got req=%b v=%b want req=1 v=0", bus.exc_req, bus.mvalid); end
`ifdef OVF_STAT_EN
        n_cmp++; if (bus.ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL dbl_cnt: got %0d want 1", bus.ovf_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        idle();
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (bus.exc_req !== 1'b0 || bus.exc_epc !== 32'h0) begin n_fail++; $display("FAIL areset_exc: got req=%b epc=%h want 0 0", bus.exc_req, bus.exc_epc); end
        n_cmp++; if (bus.malu !== 32'h0 || bus.mpc !== 32'h0 || bus.mrn !== 5'd0) begin n_fail++; $display("FAIL areset_data: got alu=%h pc=%h rn=%0d want 0", bus.malu, bus.mpc, bus.mrn); end
`ifdef OVF_STAT_EN
        n_cmp++; if (bus.ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_cnt: got %0d want 0", bus.ovf_cnt); end
`endif
        @(negedge clk);
        rst_n = 1;
        instr(32'h0000_0044, 32'h0000_0400, 5'd12, 0);
        tick();
        n_cmp++; if (bus.mvalid !== 1'b1 || bus.malu !== 32'h44 || bus.mrn !== 5'd12) begin n_fail++; $display("FAIL areset_first: got v=%b alu=%h rn=%0d want 1 44 12", bus.mvalid, bus.malu, bus.mrn); end
    endtask

    task automatic test_ack_flush();
        instr(32'h8000_0000, 32'h0000_0500, 5'd2, 1);
        tick();
        n_cmp++; if (bus.exc_req !== 1'b1) begin n_fail++; $display("FAIL ackfl_pre: got %b want 1", bus.exc_req); end
        bus.exc_ack = 1;
        bus.flush = 1;
        instr(32'h0000_0055, 32'h0000_0504, 5'd3, 0);
        tick();
        bus.exc_ack = 0;
        bus.flush = 0;
        n_cmp++; if (bus.exc_req !== 1'b0 || bus.mvalid !== 1'b0) begin n_fail++; $display("FAIL ackfl_edge: got req=%b v=%b want 0 0", bus.exc_req, bus.mvalid); end
        instr(32'h0000_0066, 32'h0000_0180, 5'd11, 0);
        tick();
        n_cmp++; if (bus.mvalid !== 1'b1 || bus.malu !== 32'h66 || bus.exc_req !== 1'b0) begin n_fail++; $display("FAIL ackfl_next: got v=%b alu=%h req=%b want 1 66 0", bus.mvalid, bus.malu, bus.exc_req); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 0;
        idle();
        test_reset();
        test_normal();
        test_overflow();
        test_stall_flush();
        test_double_fault();
        test_async_reset();
        test_ack_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
